// File: rtl/exc_pkg.sv
// Shared definitions for the LEGv8 exception/interrupt controller:
// cause codes, FSM state encoding and small helpers.
package exc_pkg;

  localparam int ESTATUS_W = 4;
  localparam int IRQ_IDX_W = 3;

  localparam logic [ESTATUS_W-1:0] CAUSE_NONE       = 4'b0000;
  localparam logic [ESTATUS_W-1:0] CAUSE_BAD_OPCODE = 4'b0010;
  localparam logic [ESTATUS_W-1:0] CAUSE_IRQ_BASE   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SIGNAL  = 2'b01,
    HANDLER = 2'b10
  } exc_state_t;

  // Cause code for interrupt line idx: 4'b1000 + idx
  function automatic logic [ESTATUS_W-1:0] irq_cause(input logic [IRQ_IDX_W-1:0] idx);
    return CAUSE_IRQ_BASE | {1'b0, idx};
  endfunction

endpackage

// File: rtl/exc_pending.sv
// Rising-edge detector and pending latch for the external interrupt lines.
// A set (rising edge) wins over a clear of the same bit in the same cycle.
module exc_pending
  import exc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] pending_o
);

  logic [W-1:0] prevLevel_q;
  logic [W-1:0] pending_q;
  logic [W-1:0] pending_d;
  logic [W-1:0] rise;

  // A line rises when it is high now and was low at the previous edge
  always_comb begin
    rise      = level_i & ~prevLevel_q;
    pending_d = (pending_q & ~clr_i) | rise;
  end

  // Edge history and pending bits, both cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevLevel_q <= '0;
      pending_q   <= '0;
    end else begin
      prevLevel_q <= level_i;
      pending_q   <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/exc_arbiter.sv
// Exception/interrupt controller: latches a synchronous bad-opcode fault
// and NIRQ interrupt lines, selects one by fixed priority, raises Exc until
// the datapath acknowledges, then blocks further exceptions until ERET.
// Optional build macro: EXC_IRQ_MASK_EN adds the irq_mask input.
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int NIRQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bad_opcode,
  input  logic [NIRQ-1:0]      irq,
`ifdef EXC_IRQ_MASK_EN
  input  logic [NIRQ-1:0]      irq_mask,
`endif
  input  logic                 ExcAck,
  input  logic                 ERet,
  output logic                 Exc,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic                 in_handler,
  output logic                 double_fault,
  output logic [NIRQ-1:0]      irq_pending
);

  exc_state_t           state_q, state_d;
  logic [ESTATUS_W-1:0] estatus_q, estatus_d;
  logic                 syncPending_q, syncPending_d;
  logic                 doubleFault_q, doubleFault_d;
  logic                 exc_q;
  logic                 inHandler_q;

  logic [NIRQ-1:0]      irqPending;
  logic [NIRQ-1:0]      irqClr;
  logic [NIRQ-1:0]      irqEnable;
  logic [NIRQ-1:0]      eligible;
  logic                 syncClr;
  logic                 irqFound;
  logic [IRQ_IDX_W-1:0] irqWinner;

  exc_pending #(
    .W(NIRQ)
  ) u_pending (
    .clk      (clk),
    .reset    (reset),
    .level_i  (irq),
    .clr_i    (irqClr),
    .pending_o(irqPending)
  );

`ifdef EXC_IRQ_MASK_EN
  assign irqEnable = irq_mask;
`else
  assign irqEnable = '1;
`endif

  assign eligible = irqPending & irqEnable;

  // Lowest-index eligible interrupt line wins
  always_comb begin
    irqFound  = 1'b0;
    irqWinner = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (eligible[i] && !irqFound) begin
        irqFound  = 1'b1;
        irqWinner = IRQ_IDX_W'(i);
      end
    end
  end

  // Next state, cause capture and pending-clear generation
  always_comb begin
    state_d   = state_q;
    estatus_d = estatus_q;
    irqClr    = '0;
    syncClr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // bad_opcode bypasses the latch so a fault is signalled one cycle later
        if (syncPending_q || bad_opcode) begin
          estatus_d = CAUSE_BAD_OPCODE;
          state_d   = SIGNAL;
        end else if (irqFound) begin
          estatus_d = irq_cause(irqWinner);
          state_d   = SIGNAL;
        end
      end
      SIGNAL: begin
        if (ExcAck) begin
          if (estatus_q == CAUSE_BAD_OPCODE) begin
            syncClr = 1'b1;
          end else begin
            for (int i = 0; i < NIRQ; i++) begin
              if (estatus_q[IRQ_IDX_W-1:0] == IRQ_IDX_W'(i)) irqClr[i] = 1'b1;
            end
          end
          estatus_d = CAUSE_NONE;
          state_d   = HANDLER;
        end
      end
      HANDLER: begin
        if (ERet) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        estatus_d = CAUSE_NONE;
      end
    endcase
  end

  // Fault bookkeeping: faults inside the handler are double faults, not new requests
  always_comb begin
    syncPending_d = (syncPending_q & ~syncClr) | (bad_opcode & (state_q != HANDLER));
    doubleFault_d = doubleFault_q | (bad_opcode & (state_q == HANDLER));
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      estatus_q     <= CAUSE_NONE;
      syncPending_q <= 1'b0;
      doubleFault_q <= 1'b0;
      exc_q         <= 1'b0;
      inHandler_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      estatus_q     <= estatus_d;
      syncPending_q <= syncPending_d;
      doubleFault_q <= doubleFault_d;
      exc_q         <= (state_d == SIGNAL);
      inHandler_q   <= (state_d == HANDLER);
    end
  end

  assign Exc          = exc_q;
  assign EStatus      = estatus_q;
  assign in_handler   = inHandler_q;
  assign double_fault = doubleFault_q;
  assign irq_pending  = irqPending;

endmodule
